gray_ptr_sync_flags: RTL and testbench
======================================

// Module: gray_ptr_sync_flags
// PURPOSE
//  Parametrised gray-pointer CDC synchroniser for the async FIFO.
//  - Moves the remote domain's gray pointer through SYNC_STAGES flops.
//  - Converts it to binary and computes fill level and the full or empty flag
//    against the local binary pointer.
//  - Flags illegal multi-bit gray transitions.
//  - One instance per side: SIDE=0 in the write domain, SIDE=1 in the read domain.
// PARAMETERS
//  ADDRESS_WIDTH  4  FIFO depth = 2**ADDRESS_WIDTH; pointers are ADDRESS_WIDTH+1 bits
//  SYNC_STAGES    2  synchroniser depth; legal 2..4; out of range -> $error at elaboration
//  SIDE           0  0 = write side (Flag = full), 1 = read side (Flag = empty)
// PORTS
//  CLK          in   1     local domain clock
//  RST          in   1     asynchronous, active-low reset
//  Remote_gptr  in   AW+1  gray pointer from the other clock domain (registered there)
//  Local_bptr   in   AW+1  local binary pointer, same domain as CLK
//  Err_clr      in   1     synchronous clear of Err_multibit
//  Sync_gptr    out  AW+1  last synchroniser stage (gray)
//  Sync_bptr    out  AW+1  registered gray->binary of Sync_gptr
//  Level        out  AW+1  occupancy as seen from this side
//  Flag         out  1     SIDE=0: full; SIDE=1: empty
//  Err_multibit out  1     sticky: synchronised gray value changed by more than 1 bit
//  (AW = ADDRESS_WIDTH)
// BEHAVIOUR
//  Reset (RST=0, async)
//  - All sync stages, Sync_bptr, previous-value register and Err_multibit -> 0.
//  - Outputs at reset: Level=0; Flag=0 for SIDE=0, Flag=1 for SIDE=1
//    (with Local_bptr=0).
//  - Reset mid-operation discards all in-flight values; no partial state survives.
//  Synchroniser
//  - stage[0] <= Remote_gptr; stage[i] <= stage[i-1]; Sync_gptr = stage[SYNC_STAGES-1].
//  - A Remote_gptr value stable before edge n appears on Sync_gptr after edge
//    n+SYNC_STAGES-1.
//  - No logic is allowed between stages.
//  Binary conversion
//  - b[AW] = g[AW]; b[i] = b[i+1] ^ g[i].
//  - The result is registered into Sync_bptr, so Sync_bptr is 1 cycle behind Sync_gptr.
//  Level / Flag (combinational from the Sync_bptr register and Local_bptr)
//  - SIDE=0: Level = (Local_bptr - Sync_bptr) mod 2**(AW+1); Flag = (Level == 2**AW).
//  - SIDE=1: Level = (Sync_bptr - Local_bptr) mod 2**(AW+1); Flag = (Level == 0).
//  - Wrap-around is handled by the modulo subtraction. At pointer MSB mismatch
//    with equal low bits: full (SIDE=0) or Level=2**AW (SIDE=1).
//  - Local pointer changes are reflected in the same cycle, so flags are pessimistic.
//  - Remote pointer changes are reflected after SYNC_STAGES+1 edges.
//  Error detection
//  - A prev register holds Sync_gptr from the previous cycle.
//  - If popcount(Sync_gptr ^ prev) > 1, Err_multibit <= 1 on the next edge.
//  - Level > 2**AW also sets Err_multibit.
//  - Err_clr=1 clears Err_multibit; if a set and Err_clr occur in the same
//    cycle, set wins.
//  - The error flag has no other effect: Level/Flag continue from the received value.
// TESTING (AW=4, SYNC_STAGES=2 unless stated)
//  1. Reset asserted mid-stream with Remote_gptr=5'b01100 -> all outputs 0
//     immediately (SIDE=1: Flag=1); after release, Sync_gptr = 5'b01100 after
//     2 edges and Sync_bptr = 5'b01000 after 3 edges.
//  2. SIDE=0, Local_bptr=16, Remote_gptr=gray(0)=0 -> Level=16, Flag=1.
//     Then Remote_gptr=gray(1)=5'b00001 -> Flag=0 after 3 edges.
//  3. SIDE=1, Local_bptr=31, remote steps gray(31) -> gray(0) (wrap) ->
//     Level 0 -> 1, Flag 1 -> 0; Err_multibit stays 0.
//  4. Remote_gptr jumps 5'b00000 -> 5'b00011 -> Err_multibit=1 one edge after
//     Sync_gptr changes. Err_clr pulsed while another 2-bit jump arrives ->
//     Err_multibit stays 1; a lone Err_clr -> 0.
//  5. SYNC_STAGES=3 and 4: a single-step change is seen on Sync_gptr after
//     exactly 3 and 4 edges respectively.
//  6. Random monotonic gray stream (1 step per remote clock, ratio 1:2.7)
//     -> Level is never > 16, no Err, and the flags match a reference model
//     delayed by SYNC_STAGES+1.

Source files
------------

// File: rtl/gray_ptr_sync_flags_if.sv
// Pointer-exchange bundle between the async FIFO core and one gray-pointer synchroniser.
// master = FIFO side that drives pointers; slave = the synchroniser.
interface gray_ptr_sync_flags_if #(
  parameter int ADDRESS_WIDTH = 4
);
  logic [ADDRESS_WIDTH:0] Remote_gptr;
  logic [ADDRESS_WIDTH:0] Local_bptr;
  logic                   Err_clr;
  logic [ADDRESS_WIDTH:0] Sync_gptr;
  logic [ADDRESS_WIDTH:0] Sync_bptr;
  logic [ADDRESS_WIDTH:0] Level;
  logic                   Flag;
  logic                   Err_multibit;

  modport master (
    output Remote_gptr, Local_bptr, Err_clr,
    input  Sync_gptr, Sync_bptr, Level, Flag, Err_multibit
  );

  modport slave (
    input  Remote_gptr, Local_bptr, Err_clr,
    output Sync_gptr, Sync_bptr, Level, Flag, Err_multibit
  );
endinterface

// File: rtl/gray_ptr_sync_flags.sv
// Gray-pointer CDC synchroniser with fill level, full/empty flag and
// detection of illegal multi-bit gray steps. SIDE=0 write domain, SIDE=1 read domain.
module gray_ptr_sync_flags #(
  parameter int ADDRESS_WIDTH = 4,
  parameter int SYNC_STAGES   = 2,
  parameter int SIDE          = 0
) (
  input  logic                  CLK,
  input  logic                  RST,
  gray_ptr_sync_flags_if.slave  bus
);
  localparam int PW = ADDRESS_WIDTH + 1;
  localparam logic [PW-1:0] FULL_LVL = {1'b1, {ADDRESS_WIDTH{1'b0}}};

  if ((SYNC_STAGES < 2) || (SYNC_STAGES > 4)) begin : g_bad_stages
    $error("gray_ptr_sync_flags: SYNC_STAGES must be in 2..4");
  end

  logic [PW-1:0] stage [SYNC_STAGES];
  logic [PW-1:0] sync_bptr;
  logic [PW-1:0] prev_gptr;
  logic [PW-1:0] level;
  logic          flag;
  logic          err_multibit;
  logic          multi_step;
  logic          level_over;

  function automatic logic [PW-1:0] gray2bin(input logic [PW-1:0] g);
    logic [PW-1:0] b;
    b[PW-1] = g[PW-1];
    for (int i = PW - 2; i >= 0; i--) b[i] = b[i+1] ^ g[i];
    return b;
  endfunction

  // Plain flop chain: nothing may sit between stages.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      for (int i = 0; i < SYNC_STAGES; i++) stage[i] <= '0;
    end else begin
      stage[0] <= bus.Remote_gptr;
      for (int i = 1; i < SYNC_STAGES; i++) stage[i] <= stage[i-1];
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      sync_bptr <= '0;
      prev_gptr <= '0;
    end else begin
      sync_bptr <= gray2bin(stage[SYNC_STAGES-1]);
      prev_gptr <= stage[SYNC_STAGES-1];
    end
  end

  // Modulo subtraction in PW bits handles pointer wrap for free.
  always_comb begin
    level = '0;
    flag  = 1'b0;
    if (SIDE == 0) begin
      level = bus.Local_bptr - sync_bptr;
      flag  = (level == FULL_LVL);
    end else begin
      level = sync_bptr - bus.Local_bptr;
      flag  = (level == '0);
    end
  end

  assign multi_step = ($countones(stage[SYNC_STAGES-1] ^ prev_gptr) > 1);
  assign level_over = (level > FULL_LVL);

  // Set has priority over clear so a fresh violation is never lost.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      err_multibit <= 1'b0;
    end else if (multi_step || level_over) begin
      err_multibit <= 1'b1;
    end else if (bus.Err_clr) begin
      err_multibit <= 1'b0;
    end
  end

  assign bus.Sync_gptr    = stage[SYNC_STAGES-1];
  assign bus.Sync_bptr    = sync_bptr;
  assign bus.Level        = level;
  assign bus.Flag         = flag;
  assign bus.Err_multibit = err_multibit;
endmodule

// File: tb/tb_gray_ptr_sync_flags.sv
// Directed bench for gray_ptr_sync_flags: four instances (write/read side,
// 2/3/4 sync stages) sharing one clock and reset.
module tb_gray_ptr_sync_flags;
  logic CLK = 1'b0;
  logic RST = 1'b0;
  int   n_checks = 0;
  int   n_errors = 0;

  always #5 CLK = ~CLK;

  gray_ptr_sync_flags_if #(.ADDRESS_WIDTH(4)) if0 ();
  gray_ptr_sync_flags_if #(.ADDRESS_WIDTH(4)) if1 ();
  gray_ptr_sync_flags_if #(.ADDRESS_WIDTH(4)) if3 ();
  gray_ptr_sync_flags_if #(.ADDRESS_WIDTH(4)) if4 ();

  gray_ptr_sync_flags #(.ADDRESS_WIDTH(4), .SYNC_STAGES(2), .SIDE(0)) dut0 (.CLK(CLK), .RST(RST), .bus(if0.slave));
  gray_ptr_sync_flags #(.ADDRESS_WIDTH(4), .SYNC_STAGES(2), .SIDE(1)) dut1 (.CLK(CLK), .RST(RST), .bus(if1.slave));
  gray_ptr_sync_flags #(.ADDRESS_WIDTH(4), .SYNC_STAGES(3), .SIDE(0)) dut3 (.CLK(CLK), .RST(RST), .bus(if3.slave));
  gray_ptr_sync_flags #(.ADDRESS_WIDTH(4), .SYNC_STAGES(4), .SIDE(0)) dut4 (.CLK(CLK), .RST(RST), .bus(if4.slave));

  task automatic init_all();
    if0.Remote_gptr = '0; if0.Local_bptr = '0; if0.Err_clr = 1'b0;
    if1.Remote_gptr = '0; if1.Local_bptr = '0; if1.Err_clr = 1'b0;
    if3.Remote_gptr = '0; if3.Local_bptr = '0; if3.Err_clr = 1'b0;
    if4.Remote_gptr = '0; if4.Local_bptr = '0; if4.Err_clr = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge CLK); RST = 1'b0;
    @(negedge CLK); RST = 1'b1;
  endtask

  task automatic test_reset();
    init_all();
    if0.Remote_gptr = 5'b00001; if1.Remote_gptr = 5'b00001; @(negedge CLK);
    if0.Remote_gptr = 5'b00011; if1.Remote_gptr = 5'b00011; @(negedge CLK);
    if0.Remote_gptr = 5'b01100; if1.Remote_gptr = 5'b01100;
    @(posedge CLK); #2 RST = 1'b0; #1;
    n_checks++; if (if0.Sync_gptr !== 5'd0) begin n_errors++; $display("FAIL rst_sync_gptr0 got %b exp 00000", if0.Sync_gptr); end
    n_checks++; if (if0.Sync_bptr !== 5'd0) begin n_errors++; $display("FAIL rst_sync_bptr0 got %b exp 00000", if0.Sync_bptr); end
    n_checks++; if (if0.Level !== 5'd0 || if0.Flag !== 1'b0) begin n_errors++; $display("FAIL rst_side0 level=%0d flag=%b exp 0/0", if0.Level, if0.Flag); end
    n_checks++; if (if1.Level !== 5'd0 || if1.Flag !== 1'b1) begin n_errors++; $display("FAIL rst_side1 level=%0d flag=%b exp 0/1", if1.Level, if1.Flag); end
    n_checks++; if (if0.Err_multibit !== 1'b0 || if1.Err_multibit !== 1'b0) begin n_errors++; $display("FAIL rst_err got %b%b exp 00", if0.Err_multibit, if1.Err_multibit); end
    @(negedge CLK); RST = 1'b1;
    @(negedge CLK);
    n_checks++; if (if1.Sync_gptr !== 5'd0) begin n_errors++; $display("FAIL rst_edge1_gptr got %b exp 00000", if1.Sync_gptr); end
    @(negedge CLK);
    n_checks++; if (if1.Sync_gptr !== 5'b01100) begin n_errors++; $display("FAIL rst_edge2_gptr got %b exp 01100", if1.Sync_gptr); end
    n_checks++; if (if1.Sync_bptr !== 5'd0) begin n_errors++; $display("FAIL rst_edge2_bptr got %b exp 00000", if1.Sync_bptr); end
    @(negedge CLK);
    n_checks++; if (if1.Sync_bptr !== 5'b01000) begin n_errors++; $display("FAIL rst_edge3_bptr got %b exp 01000", if1.Sync_bptr); end
    n_checks++; if (if1.Level !== 5'd8 || if1.Flag !== 1'b0) begin n_errors++; $display("FAIL rst_edge3_level level=%0d flag=%b exp 8/0", if1.Level, if1.Flag); end
  endtask

  task automatic test_full();
    init_all(); do_reset();
    if0.Local_bptr = 5'd16; #1;
    n_checks++; if (if0.Level !== 5'd16 || if0.Flag !== 1'b1) begin n_errors++; $display("FAIL full_initial level=%0d flag=%b exp 16/1", if0.Level, if0.Flag); end
    if0.Remote_gptr = 5'b00001;
    for (int k = 1; k <= 3; k++) begin
      @(negedge CLK);
      if (k < 3) begin
        n_checks++; if (if0.Flag !== 1'b1 || if0.Level !== 5'd16) begin n_errors++; $display("FAIL full_hold_e%0d level=%0d flag=%b exp 16/1", k, if0.Level, if0.Flag); end
      end else begin
        n_checks++; if (if0.Flag !== 1'b0 || if0.Level !== 5'd15) begin n_errors++; $display("FAIL full_release level=%0d flag=%b exp 15/0", if0.Level, if0.Flag); end
      end
    end
    n_checks++; if (if0.Err_multibit !== 1'b0) begin n_errors++; $display("FAIL full_err got %b exp 0", if0.Err_multibit); end
  endtask

  task automatic test_wrap();
    init_all();
    if1.Remote_gptr = 5'b10000; if1.Local_bptr = 5'd31;
    do_reset();
    repeat (3) @(negedge CLK);
    n_checks++; if (if1.Sync_bptr !== 5'd31) begin n_errors++; $display("FAIL wrap_bptr got %0d exp 31", if1.Sync_bptr); end
    n_checks++; if (if1.Level !== 5'd0 || if1.Flag !== 1'b1) begin n_errors++; $display("FAIL wrap_empty level=%0d flag=%b exp 0/1", if1.Level, if1.Flag); end
    if1.Remote_gptr = 5'b00000;
    for (int k = 1; k <= 3; k++) begin
      @(negedge CLK);
      if (k < 3) begin
        n_checks++; if (if1.Flag !== 1'b1) begin n_errors++; $display("FAIL wrap_hold_e%0d flag=%b exp 1", k, if1.Flag); end
      end else begin
        n_checks++; if (if1.Level !== 5'd1 || if1.Flag !== 1'b0) begin n_errors++; $display("FAIL wrap_after level=%0d flag=%b exp 1/0", if1.Level, if1.Flag); end
      end
    end
    n_checks++; if (if1.Err_multibit !== 1'b0) begin n_errors++; $display("FAIL wrap_err got %b exp 0", if1.Err_multibit); end
  endtask

  task automatic test_multibit();
    init_all(); do_reset();
    if1.Remote_gptr = 5'b00011;
    repeat (2) @(negedge CLK);
    n_checks++; if (if1.Sync_gptr !== 5'b00011 || if1.Err_multibit !== 1'b0) begin n_errors++; $display("FAIL mb_arrive gptr=%b err=%b exp 00011/0", if1.Sync_gptr, if1.Err_multibit); end
    @(negedge CLK);
    n_checks++; if (if1.Err_multibit !== 1'b1) begin n_errors++; $display("FAIL mb_set got %b exp 1", if1.Err_multibit); end
    if1.Remote_gptr = 5'b00110;
    repeat (2) @(negedge CLK);
    if1.Err_clr = 1'b1;
    @(negedge CLK);
    if1.Err_clr = 1'b0;
    n_checks++; if (if1.Err_multibit !== 1'b1) begin n_errors++; $display("FAIL mb_set_wins got %b exp 1", if1.Err_multibit); end
    @(negedge CLK);
    n_checks++; if (if1.Err_multibit !== 1'b1) begin n_errors++; $display("FAIL mb_sticky got %b exp 1", if1.Err_multibit); end
    if1.Err_clr = 1'b1;
    @(negedge CLK);
    if1.Err_clr = 1'b0;
    n_checks++; if (if1.Err_multibit !== 1'b0) begin n_errors++; $display("FAIL mb_clear got %b exp 0", if1.Err_multibit); end
    @(negedge CLK);
    n_checks++; if (if1.Err_multibit !== 1'b0 || if1.Level !== 5'd4) begin n_errors++; $display("FAIL mb_after err=%b level=%0d exp 0/4", if1.Err_multibit, if1.Level); end
  endtask

  task automatic test_level_err();
    init_all(); do_reset();
    if0.Local_bptr = 5'd17; #1;
    n_checks++; if (if0.Level !== 5'd17 || if0.Err_multibit !== 1'b0) begin n_errors++; $display("FAIL lvl_pre level=%0d err=%b exp 17/0", if0.Level, if0.Err_multibit); end
    @(negedge CLK);
    n_checks++; if (if0.Err_multibit !== 1'b1) begin n_errors++; $display("FAIL lvl_set got %b exp 1", if0.Err_multibit); end
    if0.Local_bptr = 5'd0; if0.Err_clr = 1'b1;
    @(negedge CLK);
    if0.Err_clr = 1'b0;
    n_checks++; if (if0.Err_multibit !== 1'b0) begin n_errors++; $display("FAIL lvl_clear got %b exp 0", if0.Err_multibit); end
  endtask

  task automatic test_stages();
    init_all(); do_reset();
    if3.Remote_gptr = 5'b00001; if4.Remote_gptr = 5'b00001;
    for (int k = 1; k <= 5; k++) begin
      @(negedge CLK);
      n_checks++; if (if3.Sync_gptr !== ((k >= 3) ? 5'd1 : 5'd0)) begin n_errors++; $display("FAIL stages3_e%0d got %b exp %0d", k, if3.Sync_gptr, (k >= 3)); end
      n_checks++; if (if4.Sync_gptr !== ((k >= 4) ? 5'd1 : 5'd0)) begin n_errors++; $display("FAIL stages4_e%0d got %b exp %0d", k, if4.Sync_gptr, (k >= 4)); end
    end
  endtask

  // FIFO A: if1 is its read side. FIFO B: if0 is its write side. Remote pointers step at 10/27 of the local rate.
  task automatic test_stream();
    logic [4:0] wa, ra, rb, wb, ha0, ha1, ha2, hb0, hb1, hb2, exp_a, exp_b, occ_a;
    int acc;
    wa = '0; ra = '0; rb = '0; wb = '0; acc = 0;
    ha0 = '0; ha1 = '0; ha2 = '0; hb0 = '0; hb1 = '0; hb2 = '0;
    init_all(); do_reset();
    for (int c = 0; c < 400; c++) begin
      if1.Remote_gptr = wa ^ (wa >> 1); if1.Local_bptr = ra;
      if0.Remote_gptr = rb ^ (rb >> 1); if0.Local_bptr = wb;
      @(negedge CLK);
      ha2 = ha1; ha1 = ha0; ha0 = wa;
      hb2 = hb1; hb1 = hb0; hb0 = rb;
      exp_a = ha2 - ra;
      exp_b = wb - hb2;
      n_checks++; if (if1.Level !== exp_a || if1.Flag !== (exp_a == 5'd0)) begin n_errors++; $display("FAIL stream_rd c=%0d level=%0d flag=%b exp %0d/%b", c, if1.Level, if1.Flag, exp_a, (exp_a == 5'd0)); end
      n_checks++; if (if0.Level !== exp_b || if0.Flag !== (exp_b == 5'd16)) begin n_errors++; $display("FAIL stream_wr c=%0d level=%0d flag=%b exp %0d/%b", c, if0.Level, if0.Flag, exp_b, (exp_b == 5'd16)); end
      n_checks++; if (if1.Level > 5'd16 || if0.Level > 5'd16) begin n_errors++; $display("FAIL stream_range c=%0d levels %0d/%0d exp <=16", c, if1.Level, if0.Level); end
      n_checks++; if (if1.Err_multibit !== 1'b0 || if0.Err_multibit !== 1'b0) begin n_errors++; $display("FAIL stream_err c=%0d got %b%b exp 00", c, if1.Err_multibit, if0.Err_multibit); end
      occ_a = wa - ra;
      acc += 10;
      if (acc >= 27) begin
        acc -= 27;
        if (occ_a < 5'd16) wa = wa + 5'd1;
        if (rb != wb) rb = rb + 5'd1;
      end
      if (exp_a != 5'd0 && $urandom_range(0, 3) != 0) ra = ra + 5'd1;
      if (exp_b != 5'd16 && $urandom_range(0, 3) != 0) wb = wb + 5'd1;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout after 200000 time units");
    $fatal(1);
  end

  initial begin
    init_all();
    repeat (2) @(negedge CLK);
    RST = 1'b1;
    test_reset();
    test_full();
    test_wrap();
    test_multibit();
    test_level_err();
    test_stages();
    test_stream();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
